ex_div_unit: RTL and testbench
==============================

// Module: ex_div_unit
// PURPOSE
//  Iterative RV64M divide/remainder unit in the Ex stage. Consumes the Id2Ex register outputs directly.
//  Handles DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW.
//  Drives DivHoldReq to Ctrl so Id2Ex and upstream stages freeze while the op is in flight.
//  Ex selects DivResult for the writeback path in the cycle DivValid is high.
// PARAMETERS
//  XLEN     64  datapath width; word (W) ops use XLEN/2
//  CNT_W    7   iteration counter width, $clog2(XLEN)+1
// PORTS
//  Clk            in   1     clock, rising edge
//  Rst            in   1     reset, asynchronous, active-low
//  OpCodeIn       in   7     from Id2Ex
//  Funct3In       in   3     from Id2Ex
//  Funct7In       in   7     from Id2Ex
//  Rs1ReadDataIn  in   XLEN  dividend
//  Rs2ReadDataIn  in   XLEN  divisor
//  RdAddrIn       in   5     destination register
//  FlushIn        in   1     Ctrl jump/flush; aborts the op in flight
//  DivHoldReq     out  1     stall request to Ctrl
//  DivValid       out  1     result valid, one-cycle pulse
//  DivResult      out  XLEN  quotient or remainder
//  DivRdAddr      out  5     rd of the completed op
// BEHAVIOUR
//  Decode: start = Funct7In==7'b0000001 && Funct3In[2] && OpCodeIn in {7'b0110011, 7'b0111011}.
//   Signed = !Funct3In[0]; Rem = Funct3In[1]; Word = OpCodeIn==7'b0111011.
//  Operand prep:
//   Word ops take the low 32 bits, sign-extended if Signed, else zero-extended.
//   Signed ops divide magnitudes.
//   Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
//  Word results: low 32 bits, sign-extended to XLEN. DIVUW/REMUW are also sign-extended.
//  States:
//   IDLE
//    - start && special case -> DONE
//    - start -> CALC: latch operands, RdAddr, flags; counter = N-1 (N = XLEN, or XLEN/2 if Word)
//    - otherwise stay in IDLE
//   CALC: restoring radix-2, one quotient bit per cycle.
//    - R = {R, a_msb} - b; keep R if the subtraction does not go negative.
//    - counter==0 -> DONE, else decrement.
//   DONE: apply signs, drive DivValid=1 and DivResult; -> IDLE next edge.
//  Special cases, resolved in IDLE in 0 iterations:
//   - divisor==0: quotient all ones; remainder = dividend (after word prep).
//   - Signed && dividend==most-negative && divisor==-1: quotient = dividend; remainder 0.
//  DivHoldReq = (IDLE && start && !FlushIn) || CALC. It is combinational; Ctrl sees it in the same cycle.
//   It is low in DONE, so the held instruction retires and Id2Ex advances on the next edge.
//  Latency, start to DivValid:
//   - normal: N+1 hold cycles, then 1 DONE cycle.
//   - special case: 1 hold cycle, then DONE.
//  start is ignored in DONE: the same instruction is still present and must not re-launch.
//   A new div op may start in the IDLE cycle after DONE.
//  FlushIn in any state -> IDLE next edge. The same cycle drives DivHoldReq=0 and DivValid=0.
//   No result is produced for a flushed op. Flush has priority over start.
//  Reset: state IDLE, counter 0, internal regs 0. Outputs DivHoldReq=0, DivValid=0, DivResult=0, DivRdAddr=0.
//   Reset mid-CALC discards the op.
//  DivResult and DivRdAddr hold their last value outside DONE. Consumers qualify them with DivValid.
// TESTING
//  1 DIV 100/7, rd=5 -> DivHoldReq high 65 cycles, then DivValid=1, DivResult=14, DivRdAddr=5; REM -> 2
//  2 DIVU x/0 -> 1 hold cycle, then DivResult=64'hFFFF_FFFF_FFFF_FFFF; REMU 123/0 -> 123
//  3 DIV 64'h8000_0000_0000_0000 / -1 -> 64'h8000_0000_0000_0000; REM -> 0; 1 hold cycle
//  4 DIVW -7/2 -> 64'hFFFF_FFFF_FFFF_FFFD, REMW -> 64'hFFFF_FFFF_FFFF_FFFF, 33 hold cycles
//    DIVUW 32'h8000_0000/1 -> 64'hFFFF_FFFF_8000_0000
//  5 FlushIn pulse on 10th CALC cycle -> IDLE, no DivValid; next DIV 9/3 -> 3 after 65 hold cycles
//  6 Rst low mid-CALC -> all outputs 0 immediately; ADD (Funct7=0) -> DivHoldReq stays 0

Source files
------------

// File: rtl/ex_div_unit.sv
// Iterative RV64M divide/remainder unit for the Ex stage.
// Restoring radix-2 division, one quotient bit per cycle, stalls Id2Ex while busy.
module ex_div_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [6:0]      OpCodeIn,
  input  logic [2:0]      Funct3In,
  input  logic [6:0]      Funct7In,
  input  logic [XLEN-1:0] Rs1ReadDataIn,
  input  logic [XLEN-1:0] Rs2ReadDataIn,
  input  logic [4:0]      RdAddrIn,
  input  logic            FlushIn,
  output logic            DivHoldReq,
  output logic            DivValid,
  output logic [XLEN-1:0] DivResult,
  output logic [4:0]      DivRdAddr
);

  localparam int HALF = XLEN / 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   quoReg;
  logic [XLEN-1:0]   remReg;
  logic [XLEN-1:0]   divReg;
  logic [4:0]        rdReg;
  logic              remSel;
  logic              wordSel;
  logic              qNeg;
  logic              rNeg;

  logic              start;
  logic              isSigned;
  logic              isRem;
  logic              isWord;
  logic [XLEN-1:0]   aPrep;
  logic [XLEN-1:0]   bPrep;
  logic              aNeg;
  logic              bNeg;
  logic [XLEN-1:0]   aMag;
  logic [XLEN-1:0]   bMag;
  logic [XLEN-1:0]   minNeg;
  logic              divZero;
  logic              overflow;
  logic              special;
  logic [XLEN-1:0]   specRaw;
  logic [XLEN-1:0]   specResult;

  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic              fit;
  logic [XLEN-1:0]   remNext;
  logic [XLEN-1:0]   quoNext;
  logic [XLEN-1:0]   qFinal;
  logic [XLEN-1:0]   rFinal;
  logic [XLEN-1:0]   calcRaw;
  logic [XLEN-1:0]   calcResult;

  // Decode and operand preparation straight off the Id2Ex register outputs
  always_comb begin
    start    = (Funct7In == 7'b0000001) && Funct3In[2] &&
               ((OpCodeIn == 7'b0110011) || (OpCodeIn == 7'b0111011));
    isSigned = !Funct3In[0];
    isRem    = Funct3In[1];
    isWord   = (OpCodeIn == 7'b0111011);

    if (isWord) begin
      aPrep  = isSigned ? {{HALF{Rs1ReadDataIn[HALF-1]}}, Rs1ReadDataIn[HALF-1:0]}
                        : {{HALF{1'b0}}, Rs1ReadDataIn[HALF-1:0]};
      bPrep  = isSigned ? {{HALF{Rs2ReadDataIn[HALF-1]}}, Rs2ReadDataIn[HALF-1:0]}
                        : {{HALF{1'b0}}, Rs2ReadDataIn[HALF-1:0]};
      minNeg = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      aPrep  = Rs1ReadDataIn;
      bPrep  = Rs2ReadDataIn;
      minNeg = {1'b1, {(XLEN-1){1'b0}}};
    end

    aNeg = isSigned && aPrep[XLEN-1];
    bNeg = isSigned && bPrep[XLEN-1];
    aMag = aNeg ? -aPrep : aPrep;
    bMag = bNeg ? -bPrep : bPrep;

    divZero  = (bPrep == '0);
    overflow = isSigned && (aPrep == minNeg) && (bPrep == '1);
    special  = divZero || overflow;

    if (divZero) specRaw = isRem ? aPrep : '1;
    else         specRaw = isRem ? '0 : aPrep;
    specResult = isWord ? {{HALF{specRaw[HALF-1]}}, specRaw[HALF-1:0]} : specRaw;
  end

  // One restoring step; the final-cycle result is formed from the step outputs
  always_comb begin
    shifted = {remReg, quoReg[XLEN-1]};
    diff    = shifted - {1'b0, divReg};
    fit     = !diff[XLEN];
    remNext = fit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quoNext = {quoReg[XLEN-2:0], fit};

    qFinal     = qNeg ? -quoNext : quoNext;
    rFinal     = rNeg ? -remNext : remNext;
    calcRaw    = remSel ? rFinal : qFinal;
    calcResult = wordSel ? {{HALF{calcRaw[HALF-1]}}, calcRaw[HALF-1:0]} : calcRaw;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      quoReg    <= '0;
      remReg    <= '0;
      divReg    <= '0;
      rdReg     <= '0;
      remSel    <= 1'b0;
      wordSel   <= 1'b0;
      qNeg      <= 1'b0;
      rNeg      <= 1'b0;
      DivResult <= '0;
      DivRdAddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !FlushIn) begin
            if (special) begin
              DivResult <= specResult;
              DivRdAddr <= RdAddrIn;
              state     <= DONE;
            end else begin
              // Word dividends sit in the upper half so the MSB-first shift
              // only walks the 32 meaningful bits.
              quoReg  <= isWord ? (aMag << HALF) : aMag;
              remReg  <= '0;
              divReg  <= bMag;
              rdReg   <= RdAddrIn;
              remSel  <= isRem;
              wordSel <= isWord;
              qNeg    <= aNeg ^ bNeg;
              rNeg    <= aNeg;
              cnt     <= isWord ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (FlushIn) begin
            state <= IDLE;
          end else begin
            quoReg <= quoNext;
            remReg <= remNext;
            if (cnt == '0) begin
              DivResult <= calcResult;
              DivRdAddr <= rdReg;
              state     <= DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Same-cycle stall and flush kill are combinational by design
  assign DivHoldReq = Rst && !FlushIn &&
                      (((state == IDLE) && start) || (state == CALC));
  assign DivValid   = (state == DONE) && !FlushIn;

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: directed div/rem vectors, special cases,
// word ops, flush and reset behaviour.
module tb_ex_div_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [6:0]  OpCodeIn;
  logic [2:0]  Funct3In;
  logic [6:0]  Funct7In;
  logic [63:0] Rs1ReadDataIn;
  logic [63:0] Rs2ReadDataIn;
  logic [4:0]  RdAddrIn;
  logic        FlushIn;
  logic        DivHoldReq;
  logic        DivValid;
  logic [63:0] DivResult;
  logic [4:0]  DivRdAddr;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          hold;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   holdCnt  = 0;

  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] OP32 = 7'b0111011;

  ex_div_unit #(.XLEN(64), .CNT_W(7)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .OpCodeIn(OpCodeIn),
    .Funct3In(Funct3In),
    .Funct7In(Funct7In),
    .Rs1ReadDataIn(Rs1ReadDataIn),
    .Rs2ReadDataIn(Rs2ReadDataIn),
    .RdAddrIn(RdAddrIn),
    .FlushIn(FlushIn),
    .DivHoldReq(DivHoldReq),
    .DivValid(DivValid),
    .DivResult(DivResult),
    .DivRdAddr(DivRdAddr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clearInstr();
    OpCodeIn      = 7'b0010011;
    Funct3In      = 3'b000;
    Funct7In      = 7'b0000000;
    Rs1ReadDataIn = '0;
    Rs2ReadDataIn = '0;
    RdAddrIn      = '0;
  endtask

  task automatic setDiv(input logic [6:0] op, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    OpCodeIn      = op;
    Funct3In      = f3;
    Funct7In      = 7'b0000001;
    Rs1ReadDataIn = a;
    Rs2ReadDataIn = b;
    RdAddrIn      = rd;
  endtask

  // Present an op until its DONE cycle, then let Id2Ex advance
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                       input logic [63:0] expRes, input int expHold);
    exp_t e;
    bit   seen;
    e.res  = expRes;
    e.rd   = rd;
    e.hold = expHold;
    sb.push_back(e);
    setDiv(op, f3, a, b, rd);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (DivValid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL timeout rd=%0d actual=no_valid expected=valid", rd);
      if (sb.size() != 0) e = sb.pop_front();
    end
    @(posedge Clk);
    #1;
    clearInstr();
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (!Rst) begin
      holdCnt = 0;
    end else if (DivHoldReq) begin
      holdCnt++;
    end else begin
      if (DivValid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=%h expected=none", DivResult);
        end else begin
          e = sb.pop_front();
          chk("result", DivResult, e.res);
          chk("rdaddr", 64'(DivRdAddr), 64'(e.rd));
          chk("hold_cycles", 64'(holdCnt), 64'(e.hold));
        end
      end
      holdCnt = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit sawValid;
    Rst     = 1'b0;
    FlushIn = 1'b0;
    clearInstr();
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_hold", 64'(DivHoldReq), 64'd0);
    chk("reset_valid", 64'(DivValid), 64'd0);
    chk("reset_result", DivResult, 64'd0);
    chk("reset_rd", 64'(DivRdAddr), 64'd0);
    Rst = 1'b1;
    @(posedge Clk);
    #1;

    issue(OP, 3'b100, 64'd100, 64'd7, 5'd5, 64'd14, 65);
    issue(OP, 3'b110, 64'd100, 64'd7, 5'd6, 64'd2, 65);
    issue(OP, 3'b100, -64'sd100, 64'd7, 5'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    issue(OP, 3'b110, -64'sd100, 64'd7, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    issue(OP, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd9, 64'h7FFF_FFFF_FFFF_FFFF, 65);
    issue(OP, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd10, 64'd1, 65);

    issue(OP, 3'b101, 64'd555, 64'd0, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    issue(OP, 3'b111, 64'd123, 64'd0, 5'd12, 64'd123, 1);
    issue(OP, 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13,
          64'h8000_0000_0000_0000, 1);
    issue(OP, 3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 64'd0, 1);

    issue(OP32, 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    issue(OP32, 3'b110, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    issue(OP32, 3'b101, 64'h0000_0000_8000_0000, 64'd1, 5'd17, 64'hFFFF_FFFF_8000_0000, 33);
    issue(OP32, 3'b100, 64'd42, 64'hFFFF_FFFF_0000_0000, 5'd18, 64'hFFFF_FFFF_FFFF_FFFF, 1);

    // Flush on the 10th CALC cycle
    setDiv(OP, 3'b100, 64'd1000, 64'd3, 5'd20);
    repeat (10) @(posedge Clk);
    #1;
    FlushIn = 1'b1;
    @(negedge Clk);
    chk("flush_hold", 64'(DivHoldReq), 64'd0);
    chk("flush_valid", 64'(DivValid), 64'd0);
    @(posedge Clk);
    #1;
    FlushIn = 1'b0;
    clearInstr();
    sawValid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge Clk);
      if (DivValid) sawValid = 1'b1;
    end
    chk("flush_no_result", 64'(sawValid), 64'd0);
    @(posedge Clk);
    #1;
    issue(OP, 3'b100, 64'd9, 64'd3, 5'd21, 64'd3, 65);

    // Reset mid-CALC
    setDiv(OP, 3'b100, 64'd1000, 64'd3, 5'd22);
    repeat (20) @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    chk("midreset_hold", 64'(DivHoldReq), 64'd0);
    chk("midreset_valid", 64'(DivValid), 64'd0);
    chk("midreset_result", DivResult, 64'd0);
    chk("midreset_rd", 64'(DivRdAddr), 64'd0);
    clearInstr();
    @(posedge Clk);
    #1;
    Rst      = 1'b1;
    OpCodeIn = OP;
    Funct3In = 3'b000;
    Funct7In = 7'b0000000;
    Rs1ReadDataIn = 64'd5;
    Rs2ReadDataIn = 64'd6;
    RdAddrIn = 5'd3;
    sawValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (DivHoldReq || DivValid) sawValid = 1'b1;
    end
    chk("add_no_hold", 64'(sawValid), 64'd0);
    clearInstr();
    repeat (2) @(posedge Clk);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
